// File: rtl/sprite_fetch_arbiter.sv
// Round-robin arbiter sharing one sprite ROM + palette mapper between NUM_REQ pixel requesters.
// A tag pipeline tracks each read in flight and routes the returned pixel back to its requester.
module sprite_fetch_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int SPR_W      = 32,
  parameter int SPR_H      = 32,
  parameter int NUM_FRAMES = 4,
  parameter int BASE_ADDR  = 0,
  parameter int XW         = 6,
  parameter int FW         = 3,
  parameter int RD_LAT     = 2
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  flush,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*XW-1:0] req_x,
  input  logic [NUM_REQ*XW-1:0] req_y,
  input  logic [NUM_REQ*FW-1:0] req_frame,
  output logic [18:0]           map_address,
  input  logic [7:0]            map_red,
  input  logic [7:0]            map_green,
  input  logic [7:0]            map_blue,
  input  logic                  map_zero,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [7:0]            rsp_red,
  output logic [7:0]            rsp_green,
  output logic [7:0]            rsp_blue,
  output logic                  rsp_zero
);

  localparam int IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NSTG = RD_LAT + 1;

  logic [IDW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]            gnt_id;
  logic [IDW-1:0]            scan_idx;
  logic                      gnt_any;
  int                        scan;

  logic [XW-1:0]             x_sel, y_sel;
  logic [FW-1:0]             frame_sel;
  logic                      oor_sel;

  logic [18:0]               map_address_q, map_address_d;

  logic [NSTG-1:0]           stg_vld_q, stg_vld_d;
  logic [NSTG-1:0][IDW-1:0]  stg_id_q, stg_id_d;
  logic [NSTG-1:0]           stg_oor_q, stg_oor_d;

  logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [7:0]                rsp_red_q, rsp_red_d;
  logic [7:0]                rsp_green_q, rsp_green_d;
  logic [7:0]                rsp_blue_q, rsp_blue_d;
  logic                      rsp_zero_q, rsp_zero_d;

  // Grant: first valid requester after rr_ptr, nothing while flushing.
  always_comb begin
    req_ready = '0;
    gnt_any   = 1'b0;
    gnt_id    = rr_ptr_q;
    scan      = 0;
    scan_idx  = '0;
    if (!flush) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        scan     = (int'(rr_ptr_q) + k) % NUM_REQ;
        scan_idx = IDW'(scan);
        if (!gnt_any && req_valid[scan_idx]) begin
          gnt_any = 1'b1;
          gnt_id  = scan_idx;
        end
      end
    end
    if (gnt_any) req_ready[gnt_id] = 1'b1;
    rr_ptr_d = gnt_any ? gnt_id : rr_ptr_q;
  end

  // Field select for the granted requester, flat ROM address and range check.
  always_comb begin
    x_sel     = '0;
    y_sel     = '0;
    frame_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        x_sel     = req_x[i*XW +: XW];
        y_sel     = req_y[i*XW +: XW];
        frame_sel = req_frame[i*FW +: FW];
      end
    end
    oor_sel = (int'(x_sel) >= SPR_W) || (int'(y_sel) >= SPR_H) ||
              (int'(frame_sel) >= NUM_FRAMES);
    map_address_d = map_address_q;
    if (gnt_any) begin
      map_address_d = 19'(BASE_ADDR) + 19'(frame_sel) * 19'(SPR_W * SPR_H) +
                      19'(y_sel) * 19'(SPR_W) + 19'(x_sel);
    end
  end

  // Tag pipeline advance; last stage lines up with the mapper output.
  always_comb begin
    stg_vld_d   = flush ? '0 : {stg_vld_q[NSTG-2:0], gnt_any};
    stg_id_d    = {stg_id_q[NSTG-2:0], gnt_id};
    stg_oor_d   = {stg_oor_q[NSTG-2:0], oor_sel};
    rsp_valid_d = '0;
    rsp_red_d   = rsp_red_q;
    rsp_green_d = rsp_green_q;
    rsp_blue_d  = rsp_blue_q;
    rsp_zero_d  = rsp_zero_q;
    if (stg_vld_q[NSTG-1] && !flush) begin
      rsp_valid_d[stg_id_q[NSTG-1]] = 1'b1;
      if (stg_oor_q[NSTG-1]) begin
        rsp_red_d   = 8'h00;
        rsp_green_d = 8'h00;
        rsp_blue_d  = 8'h00;
        rsp_zero_d  = 1'b1;
      end else begin
        rsp_red_d   = map_red;
        rsp_green_d = map_green;
        rsp_blue_d  = map_blue;
        rsp_zero_d  = map_zero;
      end
    end
  end

  // Register boundary: grant state, issued address, tags and response.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rr_ptr_q      <= IDW'(NUM_REQ - 1);
      map_address_q <= 19'(BASE_ADDR);
      stg_vld_q     <= '0;
      stg_id_q      <= '0;
      stg_oor_q     <= '0;
      rsp_valid_q   <= '0;
      rsp_red_q     <= 8'h00;
      rsp_green_q   <= 8'h00;
      rsp_blue_q    <= 8'h00;
      rsp_zero_q    <= 1'b1;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      map_address_q <= map_address_d;
      stg_vld_q     <= stg_vld_d;
      stg_id_q      <= stg_id_d;
      stg_oor_q     <= stg_oor_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_red_q     <= rsp_red_d;
      rsp_green_q   <= rsp_green_d;
      rsp_blue_q    <= rsp_blue_d;
      rsp_zero_q    <= rsp_zero_d;
    end
  end

  assign map_address = map_address_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_red     = rsp_red_q;
  assign rsp_green   = rsp_green_q;
  assign rsp_blue    = rsp_blue_q;
  assign rsp_zero    = rsp_zero_q;

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Directed bench for sprite_fetch_arbiter with a two-edge ROM/mapper model whose
// colour is a fixed function of the address (red=a[7:0], green=a[15:8]^5A, blue=a[18:16]+33).
module tb_sprite_fetch_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        flush;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [11:0] req_x, req_y;
  logic [5:0]  req_frame;
  logic [18:0] map_address;
  logic [7:0]  map_red, map_green, map_blue;
  logic        map_zero;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_red, rsp_green, rsp_blue;
  logic        rsp_zero;
  logic [18:0] a1;

  int checks   = 0;
  int failures = 0;

  sprite_fetch_arbiter dut (
    .Clk(Clk), .Reset_n(Reset_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_frame(req_frame),
    .map_address(map_address),
    .map_red(map_red), .map_green(map_green), .map_blue(map_blue), .map_zero(map_zero),
    .rsp_valid(rsp_valid), .rsp_red(rsp_red), .rsp_green(rsp_green),
    .rsp_blue(rsp_blue), .rsp_zero(rsp_zero)
  );

  always #5 Clk = ~Clk;

  // ROM 1 edge + mapper 1 edge
  always @(posedge Clk) begin
    a1        <= map_address;
    map_red   <= a1[7:0];
    map_green <= a1[15:8] ^ 8'h5A;
    map_blue  <= {5'b0, a1[18:16]} + 8'h33;
    map_zero  <= (a1[7:0] == 8'hFF);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] f, input logic [5:0] x, input logic [5:0] y);
    req_frame[i*3 +: 3] = f;
    req_x[i*6 +: 6]     = x;
    req_y[i*6 +: 6]     = y;
  endtask

  function automatic logic [1:0] pat(input int c);
    return (c % 2 == 0) ? 2'b01 : 2'b10;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n   = 1'b0;
    flush     = 1'b0;
    req_valid = 2'b00;
    req_x     = '0;
    req_y     = '0;
    req_frame = '0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_addr",  32'(map_address), 32'd0);
    chk("rst_rspv",  32'(rsp_valid), 32'd0);
    chk("rst_red",   32'(rsp_red), 32'h00);
    chk("rst_green", 32'(rsp_green), 32'h00);
    chk("rst_blue",  32'(rsp_blue), 32'h00);
    chk("rst_zero",  32'(rsp_zero), 32'd1);
    chk("rst_ready", 32'(req_ready), 32'd0);
    Reset_n = 1'b1;

    // 1) single request, frame 1 (3,2)
    set_req(0, 3'd1, 6'd3, 6'd2);
    req_valid = 2'b01;
    #1 chk("t1_ready", 32'(req_ready), 32'b01);
    step;
    chk("t1_addr", 32'(map_address), 32'd1091);
    req_valid = 2'b00;
    step; chk("t1_rspv_e1", 32'(rsp_valid), 32'd0);
    step; chk("t1_rspv_e2", 32'(rsp_valid), 32'd0);
    step;
    chk("t1_rspv",  32'(rsp_valid), 32'b01);
    chk("t1_red",   32'(rsp_red), 32'h43);
    chk("t1_green", 32'(rsp_green), 32'h5E);
    chk("t1_blue",  32'(rsp_blue), 32'h33);
    chk("t1_zero",  32'(rsp_zero), 32'd0);
    step;
    chk("t1_rspv_off", 32'(rsp_valid), 32'd0);
    chk("t1_red_hold", 32'(rsp_red), 32'h43);

    // 2) both requesters held 8 cycles after a fresh reset
    Reset_n = 1'b0;
    #2 Reset_n = 1'b1;
    set_req(0, 3'd0, 6'd1, 6'd0);
    set_req(1, 3'd0, 6'd2, 6'd0);
    step;
    for (int n = 0; n <= 12; n++) begin
      if (n >= 4 && n <= 11) begin
        chk("t2_rspv", 32'(rsp_valid), 32'(pat(n - 4)));
        chk("t2_red",  32'(rsp_red), ((n - 4) % 2 == 0) ? 32'd1 : 32'd2);
      end else if (n >= 1) begin
        chk("t2_rspv_idle", 32'(rsp_valid), 32'd0);
      end
      if (n >= 1 && n <= 8)
        chk("t2_addr", 32'(map_address), ((n - 1) % 2 == 0) ? 32'd1 : 32'd2);
      req_valid = (n < 8) ? 2'b11 : 2'b00;
      #1 chk("t2_ready", 32'(req_ready), (n < 8) ? 32'(pat(n)) : 32'd0);
      step;
    end

    // 3) out-of-range x, then out-of-range frame, on requester 1
    set_req(1, 3'd0, 6'd32, 6'd0);
    req_valid = 2'b10;
    #1 chk("t3x_ready", 32'(req_ready), 32'b10);
    step;
    chk("t3x_addr", 32'(map_address), 32'd32);
    req_valid = 2'b00;
    step; step; step;
    chk("t3x_rspv",  32'(rsp_valid), 32'b10);
    chk("t3x_zero",  32'(rsp_zero), 32'd1);
    chk("t3x_red",   32'(rsp_red), 32'h00);
    chk("t3x_green", 32'(rsp_green), 32'h00);
    set_req(1, 3'd4, 6'd0, 6'd0);
    req_valid = 2'b10;
    #1 chk("t3f_ready", 32'(req_ready), 32'b10);
    step;
    chk("t3f_addr", 32'(map_address), 32'd4096);
    req_valid = 2'b00;
    step; step; step;
    chk("t3f_rspv",  32'(rsp_valid), 32'b10);
    chk("t3f_zero",  32'(rsp_zero), 32'd1);
    chk("t3f_green", 32'(rsp_green), 32'h00);

    // 4) two grants then flush kills both; flush blocks grant, rr_ptr holds
    set_req(0, 3'd0, 6'd5, 6'd0);
    set_req(1, 3'd0, 6'd6, 6'd0);
    req_valid = 2'b01;
    #1 chk("t4_g1", 32'(req_ready), 32'b01);
    step;
    req_valid = 2'b10;
    #1 chk("t4_g2", 32'(req_ready), 32'b10);
    step;
    flush     = 1'b1;
    req_valid = 2'b11;
    #1 chk("t4_flush_ready", 32'(req_ready), 32'd0);
    step;
    chk("t4_addr_hold", 32'(map_address), 32'd6);
    flush = 1'b0;
    #1 chk("t4_ptr_hold", 32'(req_ready), 32'b01);
    req_valid = 2'b00;
    for (int n = 0; n < 4; n++) begin
      step;
      chk("t4_rspv", 32'(rsp_valid), 32'd0);
    end
    // flush on the same edge a response is due
    set_req(0, 3'd0, 6'd7, 6'd0);
    req_valid = 2'b01;
    step;
    req_valid = 2'b00;
    step; step;
    flush = 1'b1;
    step;
    flush = 1'b0;
    chk("t4_sim_rspv", 32'(rsp_valid), 32'd0);
    step;
    chk("t4_sim_rspv2", 32'(rsp_valid), 32'd0);

    // 5) async reset mid-stream
    set_req(0, 3'd0, 6'd9, 6'd0);
    set_req(1, 3'd0, 6'd10, 6'd0);
    req_valid = 2'b11;
    step; step; step; step;
    chk("t5_pre_rspv", 32'(rsp_valid), 32'b10);
    #2 Reset_n = 1'b0;
    #1;
    chk("t5_addr",  32'(map_address), 32'd0);
    chk("t5_rspv",  32'(rsp_valid), 32'd0);
    chk("t5_red",   32'(rsp_red), 32'h00);
    chk("t5_zero",  32'(rsp_zero), 32'd1);
    chk("t5_ready", 32'(req_ready), 32'b01);
    req_valid = 2'b00;
    step;
    #3 Reset_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step;
      chk("t5_drop_rspv", 32'(rsp_valid), 32'd0);
    end
    req_valid = 2'b11;
    #1 chk("t5_first_gnt", 32'(req_ready), 32'b01);
    req_valid = 2'b00;

    // 6) in-range pixel the mapper reports transparent
    set_req(0, 3'd3, 6'd31, 6'd7);
    req_valid = 2'b01;
    #1 chk("t6_ready", 32'(req_ready), 32'b01);
    step;
    chk("t6_addr", 32'(map_address), 32'hCFF);
    req_valid = 2'b00;
    step; step; step;
    chk("t6_rspv",  32'(rsp_valid), 32'b01);
    chk("t6_zero",  32'(rsp_zero), 32'd1);
    chk("t6_red",   32'(rsp_red), 32'hFF);
    chk("t6_green", 32'(rsp_green), 32'h56);
    chk("t6_blue",  32'(rsp_blue), 32'h33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
